// File: rtl/counter_seq_pkg.sv
// Shared encodings for the counter sequencer: command ops, count modes and FSM states.
package counter_seq_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_BOUNCE   = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // The reserved encoding behaves as one-shot.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   return MODE_PERIODIC;
            2'b10:   return MODE_BOUNCE;
            default: return MODE_ONESHOT;
        endcase
    endfunction

endpackage

// File: rtl/updown_counter_dp.sv
// Up/down counter register; load has priority over a count step.
module updown_counter_dp #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= up ? count + WIDTH'(1) : count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven sequencer for an up/down counter: one-shot, periodic and bounce modes.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [1:0]       cfg_mode,
    input  logic             cfg_dir,
    input  logic [WIDTH-1:0] cfg_limit,
    output logic [WIDTH-1:0] count,
    output logic             dir_o,
    output logic             busy,
    output logic             tc_pulse,
    output logic             done
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] limit_q, limit_d;

    logic             dp_en, dp_up, dp_load;
    logic [WIDTH-1:0] dp_load_val;
    logic             cmd_acc, step_ok, at_term;
    logic [WIDTH-1:0] start_val, term_val;

    assign cmd_acc   = cmd_valid & cmd_ready;
    assign start_val = dir_q ? '0 : limit_q;
    assign term_val  = dir_q ? limit_q : '0;
    assign at_term   = (count == term_val);
    // STOP and LOAD take the edge; START and NOP let a running counter keep stepping.
    assign step_ok   = (state_q == ST_RUN) &&
                       !(cmd_acc && (cmd_op == OP_STOP || cmd_op == OP_LOAD));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_ONESHOT;
            dir_q   <= 1'b1;
            limit_q <= '1;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            limit_q <= limit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        dir_d       = dir_q;
        limit_d     = limit_q;
        dp_en       = 1'b0;
        dp_up       = dir_q;
        dp_load     = 1'b0;
        dp_load_val = start_val;

        if (cmd_acc) begin
            case (cmd_op)
                OP_LOAD: begin
                    mode_d      = decode_mode(cfg_mode);
                    dir_d       = cfg_dir;
                    limit_d     = cfg_limit;
                    dp_load     = 1'b1;
                    dp_load_val = cfg_dir ? '0 : cfg_limit;
                    if (state_q == ST_DONE) state_d = ST_IDLE;
                end
                OP_START: begin
                    if (state_q == ST_IDLE || state_q == ST_PAUSE) begin
                        state_d = ST_RUN;
                    end else if (state_q == ST_DONE) begin
                        state_d = ST_RUN;
                        dp_load = 1'b1;
                    end
                end
                OP_STOP: begin
                    if (state_q == ST_RUN) begin
                        state_d = ST_PAUSE;
                    end else if (state_q == ST_PAUSE) begin
                        state_d = ST_IDLE;
                        dp_load = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (step_ok) begin
            if (!at_term) begin
                dp_en = 1'b1;
            end else begin
                case (mode_q)
                    MODE_PERIODIC: dp_load = 1'b1;
                    MODE_BOUNCE: begin
                        // Turn around and take the first step the other way on the same edge.
                        dir_d = ~dir_q;
                        dp_up = ~dir_q;
                        dp_en = (limit_q != '0);
                    end
                    default: state_d = ST_DONE;
                endcase
            end
        end
    end

    always_comb begin
        cmd_ready = rst;
        busy      = (state_q == ST_RUN);
        done      = (state_q == ST_DONE);
        tc_pulse  = (state_q == ST_RUN) && at_term;
        dir_o     = dir_q;
    end

    updown_counter_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk      (clk),
        .rst      (rst),
        .en       (dp_en),
        .up       (dp_up),
        .load     (dp_load),
        .load_val (dp_load_val),
        .count    (count)
    );

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench: directed vector table, hand sequences and a random run against a model.
module tb_counter_sequencer;

    localparam int W = 4;
    localparam logic [1:0] NOP = 2'd0, START = 2'd1, STOP = 2'd2, LOAD = 2'd3;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready, cfg_dir;
    logic [1:0]   cmd_op, cfg_mode;
    logic [W-1:0] cfg_limit, count;
    logic         dir_o, busy, tc_pulse, done;

    int checks = 0;
    int failures = 0;

    // Reference model in plain integers.
    int m_state, m_count, m_mode, m_limit;
    bit m_dir;

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic [1:0] mode;
        logic       dir;
        logic [3:0] limit;
        int         e_count;
        logic       e_busy;
        logic       e_done;
        logic       e_tc;
        logic       e_dir;
    } vec_t;
    vec_t vecs[$];

    counter_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cfg_mode  (cfg_mode),
        .cfg_dir   (cfg_dir),
        .cfg_limit (cfg_limit),
        .count     (count),
        .dir_o     (dir_o),
        .busy      (busy),
        .tc_pulse  (tc_pulse),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_start();
        return m_dir ? 0 : m_limit;
    endfunction

    function automatic int m_term();
        return m_dir ? m_limit : 0;
    endfunction

    function automatic void model_reset();
        m_state = S_IDLE; m_count = 0; m_dir = 1; m_mode = 0; m_limit = (1 << W) - 1;
    endfunction

    function automatic void model_step();
        if (m_count != m_term()) begin
            m_count = m_dir ? m_count + 1 : m_count - 1;
        end else if (m_mode == 0) begin
            m_state = S_DONE;
        end else if (m_mode == 1) begin
            m_count = m_start();
        end else begin
            m_dir = !m_dir;
            if (m_limit != 0) m_count = m_dir ? m_count + 1 : m_count - 1;
        end
    endfunction

    function automatic void model_update(input logic v, input logic [1:0] op,
                                         input logic [1:0] mode, input logic dir,
                                         input logic [3:0] lim);
        logic [1:0] eff;
        eff = v ? op : NOP;
        if (eff == LOAD) begin
            m_mode  = (mode == 2'd3) ? 0 : int'(mode);
            m_dir   = dir;
            m_limit = int'(lim);
            m_count = m_start();
            if (m_state == S_DONE) m_state = S_IDLE;
        end else if (eff == STOP) begin
            if (m_state == S_RUN) m_state = S_PAUSE;
            else if (m_state == S_PAUSE) begin
                m_state = S_IDLE;
                m_count = m_start();
            end
        end else if (eff == START && m_state != S_RUN) begin
            if (m_state == S_DONE) m_count = m_start();
            m_state = S_RUN;
        end else if (m_state == S_RUN) begin
            model_step();
        end
    endfunction

    task automatic check_model(input string tag);
        chk({tag, " count"}, 32'(count), 32'(m_count));
        chk({tag, " dir_o"}, 32'(dir_o), 32'(m_dir));
        chk({tag, " busy"}, 32'(busy), 32'(m_state == S_RUN));
        chk({tag, " done"}, 32'(done), 32'(m_state == S_DONE));
        chk({tag, " tc_pulse"}, 32'(tc_pulse), 32'(m_state == S_RUN && m_count == m_term()));
        chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    // Drive after the falling edge, advance one rising edge, sample at the next falling edge.
    task automatic tick(input logic v, input logic [1:0] op, input logic [1:0] mode,
                        input logic dir, input logic [3:0] lim);
        cmd_valid = v; cmd_op = op; cfg_mode = mode; cfg_dir = dir; cfg_limit = lim;
        @(posedge clk);
        model_update(v, op, mode, dir, lim);
        @(negedge clk);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, NOP, 2'd0, 1'b0, 4'd0);
    endtask

    task automatic addv(input logic [1:0] op, input logic [1:0] mode, input logic dir,
                        input logic [3:0] lim, input int ec, input logic eb, input logic ed,
                        input logic et, input logic edir);
        vec_t r;
        r.v = 1'b1; r.op = op; r.mode = mode; r.dir = dir; r.limit = lim;
        r.e_count = ec; r.e_busy = eb; r.e_done = ed; r.e_tc = et; r.e_dir = edir;
        vecs.push_back(r);
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0; cmd_op = NOP; cfg_mode = 2'd0; cfg_dir = 1'b0; cfg_limit = '0;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_op = NOP; cfg_mode = 2'd0; cfg_dir = 1'b0; cfg_limit = '0;
        rst = 1'b0;
        model_reset();
        #12;
        chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst count", 32'(count), 32'd0);
        chk("rst dir_o", 32'(dir_o), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst tc", 32'(tc_pulse), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_model("post-reset");

        // One-shot up, limit 5
        addv(LOAD, 2'd0, 1'b1, 4'd5, 0, 0, 0, 0, 1);
        addv(START, 2'd0, 1'b0, 4'd0, 0, 1, 0, 0, 1);
        addv(NOP, 2'd0, 1'b0, 4'd0, 1, 1, 0, 0, 1);
        addv(NOP, 2'd0, 1'b0, 4'd0, 2, 1, 0, 0, 1);
        addv(NOP, 2'd0, 1'b0, 4'd0, 3, 1, 0, 0, 1);
        addv(NOP, 2'd0, 1'b0, 4'd0, 4, 1, 0, 0, 1);
        addv(NOP, 2'd0, 1'b0, 4'd0, 5, 1, 0, 1, 1);
        addv(NOP, 2'd0, 1'b0, 4'd0, 5, 0, 1, 0, 1);
        addv(NOP, 2'd0, 1'b0, 4'd0, 5, 0, 1, 0, 1);
        // Periodic down, limit 3
        addv(LOAD, 2'd1, 1'b0, 4'd3, 3, 0, 0, 0, 0);
        addv(START, 2'd0, 1'b0, 4'd0, 3, 1, 0, 0, 0);
        addv(NOP, 2'd0, 1'b0, 4'd0, 2, 1, 0, 0, 0);
        addv(NOP, 2'd0, 1'b0, 4'd0, 1, 1, 0, 0, 0);
        addv(NOP, 2'd0, 1'b0, 4'd0, 0, 1, 0, 1, 0);
        addv(NOP, 2'd0, 1'b0, 4'd0, 3, 1, 0, 0, 0);
        addv(NOP, 2'd0, 1'b0, 4'd0, 2, 1, 0, 0, 0);
        addv(STOP, 2'd0, 1'b0, 4'd0, 2, 0, 0, 0, 0);
        addv(STOP, 2'd0, 1'b0, 4'd0, 3, 0, 0, 0, 0);
        // Bounce up, limit 2
        addv(LOAD, 2'd2, 1'b1, 4'd2, 0, 0, 0, 0, 1);
        addv(START, 2'd0, 1'b0, 4'd0, 0, 1, 0, 0, 1);
        addv(NOP, 2'd0, 1'b0, 4'd0, 1, 1, 0, 0, 1);
        addv(NOP, 2'd0, 1'b0, 4'd0, 2, 1, 0, 1, 1);
        addv(NOP, 2'd0, 1'b0, 4'd0, 1, 1, 0, 0, 0);
        addv(NOP, 2'd0, 1'b0, 4'd0, 0, 1, 0, 1, 0);
        addv(NOP, 2'd0, 1'b0, 4'd0, 1, 1, 0, 0, 1);
        addv(NOP, 2'd0, 1'b0, 4'd0, 2, 1, 0, 1, 1);
        addv(STOP, 2'd0, 1'b0, 4'd0, 2, 0, 0, 0, 1);
        addv(STOP, 2'd0, 1'b0, 4'd0, 0, 0, 0, 0, 1);
        // Limit 0 one-shot, restart from DONE
        addv(LOAD, 2'd0, 1'b1, 4'd0, 0, 0, 0, 0, 1);
        addv(START, 2'd0, 1'b0, 4'd0, 0, 1, 0, 1, 1);
        addv(NOP, 2'd0, 1'b0, 4'd0, 0, 0, 1, 0, 1);
        addv(START, 2'd0, 1'b0, 4'd0, 0, 1, 0, 1, 1);
        addv(NOP, 2'd0, 1'b0, 4'd0, 0, 0, 1, 0, 1);
        // Reserved mode behaves as one-shot
        addv(LOAD, 2'd3, 1'b0, 4'd1, 1, 0, 0, 0, 0);
        addv(START, 2'd0, 1'b0, 4'd0, 1, 1, 0, 0, 0);
        addv(NOP, 2'd0, 1'b0, 4'd0, 0, 1, 0, 1, 0);
        addv(NOP, 2'd0, 1'b0, 4'd0, 0, 0, 1, 0, 0);

        foreach (vecs[i]) begin
            tick(vecs[i].v, vecs[i].op, vecs[i].mode, vecs[i].dir, vecs[i].limit);
            chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].e_count));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].e_done));
            chk($sformatf("vec%0d tc", i), 32'(tc_pulse), 32'(vecs[i].e_tc));
            chk($sformatf("vec%0d dir_o", i), 32'(dir_o), 32'(vecs[i].e_dir));
        end

        // Pause and resume, then STOP twice back to IDLE
        tick(1'b1, LOAD, 2'd0, 1'b1, 4'd9);
        tick(1'b1, START, 2'd0, 1'b0, 4'd0);
        nop(4);
        chk("pause pre count", 32'(count), 32'd4);
        tick(1'b1, STOP, 2'd0, 1'b0, 4'd0);
        chk("pause count", 32'(count), 32'd4);
        chk("pause busy", 32'(busy), 32'd0);
        nop(2);
        chk("pause hold", 32'(count), 32'd4);
        tick(1'b1, START, 2'd0, 1'b0, 4'd0);
        nop(1);
        chk("resume count", 32'(count), 32'd5);
        check_model("resume");
        tick(1'b1, STOP, 2'd0, 1'b0, 4'd0);
        tick(1'b1, STOP, 2'd0, 1'b0, 4'd0);
        chk("idle count", 32'(count), 32'd0);
        check_model("idle");

        // Asynchronous reset mid-run
        tick(1'b1, LOAD, 2'd0, 1'b1, 4'd15);
        tick(1'b1, START, 2'd0, 1'b0, 4'd0);
        nop(6);
        chk("pre-reset count", 32'(count), 32'd6);
        cmd_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async count", 32'(count), 32'd0);
        chk("async busy", 32'(busy), 32'd0);
        chk("async ready", 32'(cmd_ready), 32'd0);
        chk("async dir_o", 32'(dir_o), 32'd1);
        chk("async tc", 32'(tc_pulse), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check_model("after async");

        // LOAD during RUN jumps to new start value and stays running
        tick(1'b1, LOAD, 2'd0, 1'b1, 4'd15);
        tick(1'b1, START, 2'd0, 1'b0, 4'd0);
        nop(7);
        chk("run7 count", 32'(count), 32'd7);
        tick(1'b1, LOAD, 2'd1, 1'b0, 4'd10);
        chk("runload count", 32'(count), 32'd10);
        chk("runload busy", 32'(busy), 32'd1);
        nop(1);
        chk("runload step", 32'(count), 32'd9);
        check_model("runload");

        // Random commands against the model
        do_reset();
        check_model("rand reset");
        for (int i = 0; i < 800; i++) begin
            logic       v;
            logic [1:0] op;
            int         r;
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 11);
            op = (r < 7) ? NOP : (r < 9) ? START : (r < 10) ? STOP : LOAD;
            tick(v, op, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)));
            check_model($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Controller that sequences a WIDTH-bit up/down counter datapath. It accepts load/start/stop commands over a valid/ready handshake and applies the configured count mode: one-shot, periodic reload, or bounce. It reports terminal count and completion to the surrounding timer/control logic. The counter register lives in a dedicated sub-module, and this block drives its enable, direction and load controls.

Parameters:
WIDTH, 4, counter and limit width in bits

Ports:
clk  input  1  clock; all state changes on posedge
rst  input  1  asynchronous reset, active-low
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at posedge
cmd_op  input  2  00 NOP, 01 START, 10 STOP, 11 LOAD
cfg_mode  input  2  00 ONESHOT, 01 PERIODIC, 10 BOUNCE, 11 reserved (treated as ONESHOT); sampled on LOAD
cfg_dir  input  1  1 = up, 0 = down; sampled on LOAD
cfg_limit  input  WIDTH  terminal bound; sampled on LOAD
count  output  WIDTH  current counter value
dir_o  output  1  current direction (changes in BOUNCE)
busy  output  1  state == RUN
tc_pulse  output  1  combinational; high while state == RUN and count == terminal value
done  output  1  state == DONE

Behaviour:
- Reset (rst low, async):
  - state IDLE; count 0; dir_o 1; stored mode ONESHOT; stored limit all-ones.
  - busy 0, done 0, tc_pulse 0; cmd_ready 0 while rst low.
- cmd_ready is 1 in every state when out of reset. No command is ever back-pressured. NOP is accepted and has no effect.
- Start value and terminal value:
  - up: start 0, terminal limit.
  - down: start limit, terminal 0.
- States: IDLE, RUN, PAUSE, DONE.
- LOAD (any state):
  - Latch mode, dir, limit.
  - count <= start value (computed from the new dir and new limit) on the accepting edge.
  - State unchanged, except DONE -> IDLE.
- START:
  - IDLE -> RUN, count unchanged.
  - PAUSE -> RUN, resumes from held count.
  - DONE -> RUN with count <= start value.
  - RUN: ignored.
- STOP:
  - RUN -> PAUSE, count held.
  - PAUSE -> IDLE, count <= start value.
  - IDLE/DONE: ignored.
- RUN stepping, each cycle with no accepted STOP or LOAD:
  - If count != terminal: count += 1 (up) or count -= 1 (down). First step happens on the edge after START is accepted.
  - If count == terminal:
    - ONESHOT: -> DONE, count holds.
    - PERIODIC: count <= start value, stay RUN.
    - BOUNCE: dir_o flips and count steps once in the new direction, in the same edge. If limit == 0, only dir_o flips.
- Simultaneous events: one command per cycle by construction. An accepted command overrides the step for that edge.
- Arithmetic: wrap never occurs. The terminal check precedes the step, so count stays within 0..limit.
- limit == 0:
  - tc_pulse high on every RUN cycle.
  - ONESHOT reaches DONE one edge after START.
- Reset mid-RUN returns to IDLE immediately; the counter value is lost.
- Up-mode ONESHOT cycle count: limit+1 RUN cycles, START to done.

Decomposition:
- Package counter_seq_pkg:
  - op encodings OP_NOP/OP_START/OP_STOP/OP_LOAD.
  - mode encodings MODE_ONESHOT/MODE_PERIODIC/MODE_BOUNCE.
  - state enum ST_IDLE/ST_RUN/ST_PAUSE/ST_DONE.
- One sub-module, updown_counter_dp:
  - Inputs: clk, rst, en, up, load, load_val.
  - Output: count.
  - Holds the count register.
- The sequencer holds the FSM, config registers and terminal compare.

Test Plan:
1. Reset, then LOAD mode=ONESHOT dir=1 limit=5, then START -> count 0,1,2,3,4,5 on consecutive edges; tc_pulse high at count 5; next edge done=1, busy=0, count stays 5.
2. LOAD PERIODIC dir=0 limit=3, START -> count 3,2,1,0,3,2,... with tc_pulse high exactly on each count=0 cycle.
3. LOAD BOUNCE dir=1 limit=2, START -> count 0,1,2,1,0,1,2; dir_o goes 0 on the edge leaving 2 and 1 on the edge leaving 0.
4. ONESHOT limit=9, START, STOP at count 4 -> count holds 4, busy=0; START -> resumes 5; STOP twice -> IDLE, count=0.
5. LOAD dir=1 limit=0, START -> tc_pulse high first RUN cycle, done=1 after one edge; START from DONE -> RUN again with count=0.
6. Drop rst while RUN at count 6 (limit 15) -> all outputs take reset values asynchronously, before the next clk edge; LOAD during RUN at count 7 -> count jumps to the new start value, state stays RUN.
